// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the RV32 pipeline hazard controller: controller states,
// forwarding select codes and the register-match helper.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_DRAIN    = 2'b10,
    ST_HALTED   = 2'b11
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // x0 is hardwired to zero, so it never produces a hazard.
  function automatic logic reg_match(input logic i_en, input logic [4:0] i_rd,
                                     input logic [4:0] i_rs);
    return i_en && (i_rd != 5'd0) && (i_rd == i_rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_select.sv
// Operand forwarding select for one execute-stage source operand.
// The memory stage holds the younger result, so it wins over writeback.
module forward_select
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic       i_we_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_we_w,
  output logic [1:0] o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (reg_match(i_we_m, i_rd_m, i_rs))      o_fwd = FWD_M;
    else if (reg_match(i_we_w, i_rd_w, i_rs)) o_fwd = FWD_W;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding, load-use stalls,
// branch flushes, data-memory waits, debug halt/drain and perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64,
  parameter int DRAIN_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       RD_E,
  input  logic             ResultSrcE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             mem_req_M,
  input  logic             mem_ready_M,
  input  logic             halt_req,
  input  logic             resume,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DRN_W  = $clog2(DRAIN_CYC + 1);

  state_e           r_state, w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [DRN_W-1:0]  r_drain_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cycles, r_flush_events;
  logic             w_lu, w_mem_miss, w_mem_hold;

  forward_select u_fwd_a (
    .i_rs(Rs1_E), .i_rd_m(RD_M), .i_we_m(RegWriteM),
    .i_rd_w(RD_W), .i_we_w(RegWriteW), .o_fwd(ForwardAE)
  );
  forward_select u_fwd_b (
    .i_rs(Rs2_E), .i_rd_m(RD_M), .i_we_m(RegWriteM),
    .i_rd_w(RD_W), .i_we_w(RegWriteW), .o_fwd(ForwardBE)
  );

  assign w_lu       = ResultSrcE && (reg_match(1'b1, RD_E, Rs1_D) || reg_match(1'b1, RD_E, Rs2_D));
  assign w_mem_miss = mem_req_M && !mem_ready_M;

  always_comb begin
    w_next = r_state;
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushW = 1'b0; halted = 1'b0;
    // Once in MEM_WAIT only ready releases the freeze, whatever mem_req does.
    w_mem_hold = (r_state == ST_MEM_WAIT) ? !mem_ready_M
                                          : (r_state != ST_HALTED) && w_mem_miss;
    if (r_state == ST_HALTED) begin
      {StallF, StallD, StallE, StallM} = 4'b1111;
      halted = 1'b1;
      if (resume) w_next = ST_RUN;
    end else if (w_mem_hold) begin
      {StallF, StallD, StallE, StallM} = 4'b1111;
      FlushW = 1'b1;
      // A wait inside an active drain keeps DRAIN with a frozen bubble count.
      if (r_state == ST_RUN || (r_state == ST_DRAIN && !halt_req)) w_next = ST_MEM_WAIT;
    end else if (r_state == ST_DRAIN && halt_req) begin
      StallF = 1'b1;
      FlushD = 1'b1;
      FlushE = PCSrcE;
      if (r_drain_cnt == DRN_W'(DRAIN_CYC - 1)) w_next = ST_HALTED;
    end else begin
      // Normal issue: RUN, a MEM_WAIT release cycle, or an abandoned drain.
      w_next = ST_RUN;
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_lu) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (halt_req && r_state == ST_RUN) begin
        w_next = ST_DRAIN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_drain_cnt    <= '0;
      r_mem_err      <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      r_state <= w_next;
      if (w_mem_hold) begin
        if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) r_wait_cnt <= r_wait_cnt + 1'b1;
        if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) r_mem_err <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (r_state == ST_DRAIN && halt_req) begin
        if (!w_mem_hold) r_drain_cnt <= (w_next == ST_HALTED) ? '0 : r_drain_cnt + 1'b1;
      end else begin
        r_drain_cnt <= '0;
      end
      if (StallF && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (FlushE && r_flush_events != '1) r_flush_events <= r_flush_events + 1'b1;
    end
  end

  assign mem_err      = r_mem_err;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run against a flag-based behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  logic clk, rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic ResultSrcE, RegWriteM, RegWriteW, PCSrcE, mem_req_M, mem_ready_M, halt_req, resume;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, halted, mem_err;
  logic [CW-1:0] stall_cycles, flush_events;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(64), .DRAIN_CYC(4)) dut (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .ResultSrcE(ResultSrcE), .RD_M(RD_M), .RegWriteM(RegWriteM),
    .RD_W(RD_W), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .mem_req_M(mem_req_M),
    .mem_ready_M(mem_ready_M), .halt_req(halt_req), .resume(resume),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .halted(halted), .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the controller's situation as independent flags.
  bit m_waiting, m_draining, m_halted, m_err;
  int m_drain_done, m_wait_len, m_stalls, m_flushes;
  logic m_mw, m_lu;
  logic [1:0] e_fa, e_fb;
  logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_halt, e_mem;

  function automatic logic [1:0] fwd_code(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                          input logic ww, input logic [4:0] rdw);
    if (wm && rdm != 0 && rdm == rs) return 2'b10;
    if (ww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  assign m_mw = mem_req_M && !mem_ready_M;
  assign m_lu = ResultSrcE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);

  always @* begin
    e_fa = fwd_code(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
    e_fb = fwd_code(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_halt, e_mem} = '0;
    if (m_halted) begin
      {e_sf, e_sd, e_se, e_sm, e_halt} = '1;
    end else if (m_waiting ? !mem_ready_M : m_mw) begin
      {e_sf, e_sd, e_se, e_sm, e_fw, e_mem} = '1;
    end else if (m_draining && halt_req) begin
      e_sf = 1; e_fd = 1; e_fe = PCSrcE;
    end else if (PCSrcE) begin
      e_fd = 1; e_fe = 1;
    end else if (m_lu) begin
      e_sf = 1; e_sd = 1; e_fe = 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_waiting <= 0; m_draining <= 0; m_halted <= 0; m_err <= 0;
      m_drain_done <= 0; m_wait_len <= 0; m_stalls <= 0; m_flushes <= 0;
    end else begin
      if (e_mem) begin
        m_wait_len <= m_wait_len + 1;
        if (m_wait_len + 1 == 64) m_err <= 1;
      end else m_wait_len <= 0;
      if (e_sf && m_stalls < SAT) m_stalls <= m_stalls + 1;
      if (e_fe && m_flushes < SAT) m_flushes <= m_flushes + 1;
      if (m_halted) begin
        if (resume) m_halted <= 0;
      end else if (m_waiting) begin
        if (mem_ready_M) m_waiting <= 0;
      end else if (m_draining && halt_req) begin
        if (!m_mw) begin
          if (m_drain_done + 1 == 4) begin
            m_draining <= 0; m_halted <= 1; m_drain_done <= 0;
          end else m_drain_done <= m_drain_done + 1;
        end
      end else begin
        m_draining <= 0; m_drain_done <= 0;
        if (m_mw) m_waiting <= 1;
        else if (!PCSrcE && !m_lu && halt_req) m_draining <= 1;
      end
    end
  end

  task automatic idle_inputs();
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W} = '0;
    {ResultSrcE, RegWriteM, RegWriteW, PCSrcE, mem_req_M, mem_ready_M, halt_req, resume} = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    #1;
    checks++;
    if ({ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, halted} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0",
        {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, halted});
    end
    checks++;
    if ({mem_err, stall_cycles, flush_events} !== '0) begin
      errors++; $display("FAIL reset_regs mem_err=%b stalls=%0d flushes=%0d exp 0", mem_err, stall_cycles, flush_events);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_forwarding();
    do_reset();
    RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; Rs1_E = 5; Rs2_E = 9; #1;
    checks++;
    if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_priority got=%b exp=10", ForwardAE); end
    checks++;
    if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwd_b_nomatch got=%b exp=00", ForwardBE); end
    RegWriteM = 0; Rs2_E = 5; #1;
    checks++;
    if (ForwardAE !== 2'b01 || ForwardBE !== 2'b01) begin
      errors++; $display("FAIL fwd_w got=%b/%b exp=01/01", ForwardAE, ForwardBE);
    end
    RegWriteM = 1; RD_M = 0; RD_W = 0; Rs1_E = 0; Rs2_E = 0; #1;
    checks++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
      errors++; $display("FAIL fwd_x0 got=%b/%b exp=00/00", ForwardAE, ForwardBE);
    end
    idle_inputs(); tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ResultSrcE = 1; RD_E = 7; Rs2_D = 7; Rs1_D = 3;
    @(negedge clk);
    checks++;
    if ({StallF, StallD, FlushE, StallE, FlushD} !== 5'b11100) begin
      errors++; $display("FAIL load_use got=%b exp=11100", {StallF, StallD, FlushE, StallE, FlushD});
    end
    tick(); idle_inputs();
    @(negedge clk);
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000 || stall_cycles !== 1) begin
      errors++; $display("FAIL load_use_release got=%b stalls=%0d exp=000 stalls=1", {StallF, StallD, FlushE}, stall_cycles);
    end
    tick();
  endtask

  task automatic test_branch_vs_lu();
    do_reset();
    ResultSrcE = 1; RD_E = 7; Rs1_D = 7; PCSrcE = 1;
    @(negedge clk);
    checks++;
    if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
      errors++; $display("FAIL branch_over_lu got=%b exp=1100", {FlushD, FlushE, StallF, StallD});
    end
    tick(); idle_inputs();
    @(negedge clk);
    checks++;
    if (flush_events !== 1 || stall_cycles !== 0) begin
      errors++; $display("FAIL branch_counters flushes=%0d stalls=%0d exp 1/0", flush_events, stall_cycles);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req_M = 1; mem_ready_M = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE} !== 7'b1111100) begin
        errors++; $display("FAIL mem_wait cyc=%0d got=%b exp=1111100", i, {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE});
      end
      tick();
    end
    mem_ready_M = 1;
    @(negedge clk);
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushW} !== 5'b00000) begin
      errors++; $display("FAIL mem_release got=%b exp=00000", {StallF, StallD, StallE, StallM, FlushW});
    end
    tick(); idle_inputs();
    @(negedge clk);
    checks++;
    if (stall_cycles !== 3 || mem_err !== 1'b0) begin
      errors++; $display("FAIL mem_wait_count stalls=%0d err=%b exp 3/0", stall_cycles, mem_err);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req_M = 1; mem_ready_M = 0;
    for (int i = 0; i < 62; i++) tick();
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", mem_err); end
    tick(); tick();
    checks++;
    if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_set got=%b exp=1", mem_err); end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (StallF !== 1'b1 || FlushW !== 1'b1) begin
      errors++; $display("FAIL timeout_still_waiting got=%b%b exp=11", StallF, FlushW);
    end
    mem_ready_M = 1; tick(); idle_inputs(); tick(); tick();
    checks++;
    if (mem_err !== 1'b1 || StallF !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky err=%b stallF=%b exp 1/0", mem_err, StallF);
    end
  endtask

  task automatic test_halt_drain();
    do_reset();
    halt_req = 1;
    @(negedge clk);
    checks++;
    if (StallF !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL halt_first got=%b%b exp=00", StallF, halted); end
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({StallF, FlushD, StallE, halted} !== 4'b1100) begin
        errors++; $display("FAIL drain cyc=%0d got=%b exp=1100", i, {StallF, FlushD, StallE, halted});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({halted, StallF, StallD, StallE, StallM, FlushD} !== 6'b111110) begin
      errors++; $display("FAIL halted got=%b exp=111110", {halted, StallF, StallD, StallE, StallM, FlushD});
    end
    tick();
    halt_req = 0; resume = 1;
    tick();
    resume = 0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || StallF !== 1'b0) begin
      errors++; $display("FAIL resume got halted=%b stallF=%b exp 0/0", halted, StallF);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    halt_req = 1; tick(); tick(); #2;
    checks++;
    if (StallF !== 1'b1) begin errors++; $display("FAIL rst_drain_pre stallF=%b exp=1", StallF); end
    rst = 1; #1;
    checks++;
    if ({StallF, FlushD, halted} !== 3'b000 || stall_cycles !== 0) begin
      errors++; $display("FAIL rst_in_drain got=%b stalls=%0d exp=000/0", {StallF, FlushD, halted}, stall_cycles);
    end
    tick(); rst = 0; idle_inputs();
    mem_req_M = 1;
    for (int i = 0; i < 66; i++) tick();
    mem_req_M = 0; #2;
    checks++;
    if (StallF !== 1'b1 || mem_err !== 1'b1) begin
      errors++; $display("FAIL rst_wait_pre stallF=%b err=%b exp 1/1", StallF, mem_err);
    end
    rst = 1; #1;
    checks++;
    if ({StallF, StallM, FlushW, mem_err} !== 4'b0000 || stall_cycles !== 0 || flush_events !== 0) begin
      errors++; $display("FAIL rst_in_wait got=%b stalls=%0d flushes=%0d exp 0000/0/0",
        {StallF, StallM, FlushW, mem_err}, stall_cycles, flush_events);
    end
    tick(); rst = 0;
  endtask

  task automatic test_random();
    logic [24:0] got, exp;
    int bad = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
      Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
      RD_E = 5'($urandom_range(0, 3)); RD_M = 5'($urandom_range(0, 3)); RD_W = 5'($urandom_range(0, 3));
      ResultSrcE = ($urandom_range(0, 3) == 0); RegWriteM = $urandom_range(0, 1);
      RegWriteW = $urandom_range(0, 1); PCSrcE = ($urandom_range(0, 5) == 0);
      mem_req_M = ($urandom_range(0, 3) == 0); mem_ready_M = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      resume = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      got = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             halted, mem_err, stall_cycles, flush_events};
      exp = {e_fa, e_fb, e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_halt, m_err,
             CW'(m_stalls), CW'(m_flushes)};
      checks++;
      if (got !== exp) begin
        errors++;
        if (bad < 10) $display("FAIL random cyc=%0d got=%h exp=%h", c, got, exp);
        bad++;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_lu();
    test_mem_wait();
    test_timeout();
    test_halt_drain();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
